priv_1_12_clint: RTL and testbench

//  Machine-level timer and software-interrupt source (CLINT) for hart 0, directly upstream of

---
 rtl/priv_1_12_clint.sv | 147 ++++++++++++++
 tb/tb_priv_1_12_clint.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/priv_1_12_clint.sv
// priv_1_12_clint: machine timer / software interrupt source for hart 0.
// Holds mtime, mtimecmp and msip behind a word-wide request/ack port and drives
// MTIP/MSIP toward the core's interrupt interface.
module priv_1_12_clint #(
    parameter int PRESCALE = 1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        req,
    input  logic        wen,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byte_en,
    output logic [31:0] rdata,
    output logic        ack,
    output logic [63:0] mtime,
    output logic        timer_int,
    output logic        soft_int
);

    localparam int            PW      = $clog2(PRESCALE + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    // Word offsets (addr[15:2]) of the architected registers
    localparam logic [13:0] OFF_MSIP  = 14'h0000;
    localparam logic [13:0] OFF_CMP_L = 14'h1000;
    localparam logic [13:0] OFF_CMP_H = 14'h1001;
    localparam logic [13:0] OFF_MT_L  = 14'h2FFE;
    localparam logic [13:0] OFF_MT_H  = 14'h2FFF;

    typedef enum logic {IDLE, ACK} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic          msip_q, msip_d;
    logic          timer_int_q, timer_int_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          accept;
    logic          wr;
    logic          tick;
    logic [31:0]   rd_val;
    logic          unused_addr_bits;

    // Sub-word address bits carry no meaning on a word-aligned port
    assign unused_addr_bits = ^addr[1:0];

    // Merge write data into an existing word, one byte lane at a time
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

    // State register and all architectural flops; reset aborts any open transfer
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            msip_q      <= 1'b0;
            timer_int_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            timer_int_q <= timer_int_d;
            rdata_q     <= rdata_d;
        end
    end

    // Next-state: accept in IDLE, always return from ACK (req held in ACK is ignored)
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: acceptance strobe and one-cycle ack
    always_comb begin
        accept = (state_q == IDLE) && req;
        wr     = accept && wen;
        ack    = (state_q == ACK);
    end

    // Read mux; unmapped offsets read as zero
    always_comb begin
        rd_val = '0;
        case (addr[15:2])
            OFF_MSIP:  rd_val = {31'b0, msip_q};
            OFF_CMP_L: rd_val = mtimecmp_q[31:0];
            OFF_CMP_H: rd_val = mtimecmp_q[63:32];
            OFF_MT_L:  rd_val = mtime_q[31:0];
            OFF_MT_H:  rd_val = mtime_q[63:32];
            default:   rd_val = '0;
        endcase
    end

    // Prescaler: tick on the cycle the count sits at PRESCALE-1
    always_comb begin
        tick    = (presc_q == PRE_MAX);
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    // Register updates; an mtime write on a tick cycle suppresses the increment entirely
    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        if (tick) mtime_d = mtime_q + 64'd1;
        if (wr) begin
            case (addr[15:2])
                OFF_MSIP:  if (byte_en[0]) msip_d = wdata[0];
                OFF_CMP_L: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], wdata, byte_en);
                OFF_CMP_H: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wdata, byte_en);
                OFF_MT_L:  mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wdata, byte_en)};
                OFF_MT_H:  mtime_d = {merge_bytes(mtime_q[63:32], wdata, byte_en), mtime_q[31:0]};
                default:   ;
            endcase
        end
    end

    // Registered compare and read-data capture (rdata is zero outside the ack cycle)
    always_comb begin
        timer_int_d = (mtime_q >= mtimecmp_q);
        rdata_d     = (accept && !wen) ? rd_val : 32'd0;
    end

    assign rdata     = rdata_q;
    assign mtime     = mtime_q;
    assign timer_int = timer_int_q;
    assign soft_int  = msip_q;

endmodule

// File: tb/tb_priv_1_12_clint.sv
// Directed bench for priv_1_12_clint: one instance at PRESCALE=1, one at PRESCALE=4.
module tb_priv_1_12_clint;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        req1 = 1'b0, req4 = 1'b0, wen = 1'b0;
    logic [15:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  byte_en = '0;
    logic [31:0] rdata1, rdata4;
    logic        ack1, ack4, ti1, ti4, si1, si4;
    logic [63:0] mtime1, mtime4;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];

    always #5 CLK = ~CLK;

    priv_1_12_clint #(.PRESCALE(1)) dut1 (
        .CLK(CLK), .nRST(nRST), .req(req1), .wen(wen), .addr(addr), .wdata(wdata),
        .byte_en(byte_en), .rdata(rdata1), .ack(ack1), .mtime(mtime1),
        .timer_int(ti1), .soft_int(si1)
    );

    priv_1_12_clint #(.PRESCALE(4)) dut4 (
        .CLK(CLK), .nRST(nRST), .req(req4), .wen(wen), .addr(addr), .wdata(wdata),
        .byte_en(byte_en), .rdata(rdata4), .ack(ack4), .mtime(mtime4),
        .timer_int(ti4), .soft_int(si4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one transfer from the current negedge; returns at the negedge of the ack cycle.
    task automatic xfer(input string tag, input bit sel4, input bit we, input logic [15:0] a,
                        input logic [31:0] d, input logic [3:0] be, input logic [31:0] exp_rd);
        bit got;
        got = 1'b0;
        wen = we; addr = a; wdata = d; byte_en = be;
        if (sel4) req4 = 1'b1; else req1 = 1'b1;
        if (!we) exp_q.push_back(exp_rd);
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge CLK);
            got = sel4 ? ack4 : ack1;
        end
        req1 = 1'b0; req4 = 1'b0;
        check({tag, "_ack"}, {63'b0, got}, 64'd1);
        if (!we) begin
            if (got) check(tag, {32'b0, (sel4 ? rdata4 : rdata1)}, {32'b0, exp_q.pop_front()});
            else void'(exp_q.pop_front());
        end
    endtask

    initial begin
        bit          found;
        logic [63:0] prev;
        int          acks;

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_mtime1", mtime1, 64'd0);
        check("rst_mtime4", mtime4, 64'd0);
        check("rst_ack", {63'b0, ack1}, 64'd0);
        check("rst_rdata", {32'b0, rdata1}, 64'd0);
        check("rst_tint", {63'b0, ti1}, 64'd0);
        check("rst_sint", {63'b0, si1}, 64'd0);

        // Test 1: free-running count for 10 cycles, then read MTIME_L
        nRST = 1'b1;
        repeat (10) @(negedge CLK);
        check("t1_mtime10", mtime1, 64'd10);
        check("t1_tint", {63'b0, ti1}, 64'd0);
        check("t1_sint", {63'b0, si1}, 64'd0);
        xfer("t1_rd_mtl", 1'b0, 1'b0, 16'hBFF8, 32'h0, 4'hF, 32'h0000_000A);

        // Test 2: compare point at 0x20
        xfer("t2_wr_cmph", 1'b0, 1'b1, 16'h4004, 32'h0, 4'hF, 32'h0);
        xfer("t2_wr_cmpl", 1'b0, 1'b1, 16'h4000, 32'h20, 4'hF, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (mtime1 == 64'h20) found = 1'b1; else @(negedge CLK);
        end
        check("t2_reach20", {63'b0, found}, 64'd1);
        check("t2_tint_at20", {63'b0, ti1}, 64'd0);
        @(negedge CLK);
        check("t2_tint_after20", {63'b0, ti1}, 64'd1);
        xfer("t2_wr_cmpl_ffff", 1'b0, 1'b1, 16'h4000, 32'hFFFF, 4'hF, 32'h0);
        check("t2_tint_in_ack", {63'b0, ti1}, 64'd1);
        @(negedge CLK);
        check("t2_tint_drop", {63'b0, ti1}, 64'd0);

        // Test 3: low-word carry, then full 64-bit wrap
        xfer("t3_wr_h5", 1'b0, 1'b1, 16'hBFFC, 32'h5, 4'hF, 32'h0);
        xfer("t3_wr_lfe", 1'b0, 1'b1, 16'hBFF8, 32'hFFFF_FFFE, 4'hF, 32'h0);
        check("t3_written", mtime1, 64'h5_FFFF_FFFE);
        @(negedge CLK);
        check("t3_lff", mtime1, 64'h5_FFFF_FFFF);
        @(negedge CLK);
        check("t3_carry", mtime1, 64'h6_0000_0000);
        xfer("t3_wr_hff", 1'b0, 1'b1, 16'hBFFC, 32'hFFFF_FFFF, 4'hF, 32'h0);
        xfer("t3_wr_lfe2", 1'b0, 1'b1, 16'hBFF8, 32'hFFFF_FFFE, 4'hF, 32'h0);
        check("t3_max_m1", mtime1, 64'hFFFF_FFFF_FFFF_FFFE);
        @(negedge CLK);
        check("t3_max", mtime1, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge CLK);
        check("t3_wrap", mtime1, 64'h0);
        check("t3_tint_hi", {63'b0, ti1}, 64'd1);
        @(negedge CLK);
        check("t3_tint_after_wrap", {63'b0, ti1}, 64'd0);

        // Test 4: MSIP lanes, unmapped offset, byte-merged mtimecmp
        xfer("t4_wr_msip", 1'b0, 1'b1, 16'h0000, 32'hFFFF_FFFF, 4'b0001, 32'h0);
        check("t4_sint1", {63'b0, si1}, 64'd1);
        xfer("t4_rd_msip", 1'b0, 1'b0, 16'h0000, 32'h0, 4'hF, 32'h1);
        xfer("t4_wr_msip_hilanes", 1'b0, 1'b1, 16'h0000, 32'h0, 4'b1110, 32'h0);
        check("t4_sint_kept", {63'b0, si1}, 64'd1);
        xfer("t4_wr_msip0", 1'b0, 1'b1, 16'h0000, 32'h0, 4'b0001, 32'h0);
        check("t4_sint0", {63'b0, si1}, 64'd0);
        xfer("t4_wr_unmapped", 1'b0, 1'b1, 16'h1234, 32'hFFFF_FFFF, 4'hF, 32'h0);
        check("t4_sint_unmapped", {63'b0, si1}, 64'd0);
        xfer("t4_rd_unmapped", 1'b0, 1'b0, 16'h1234, 32'h0, 4'hF, 32'h0);
        xfer("t4_rd_cmpl", 1'b0, 1'b0, 16'h4000, 32'h0, 4'hF, 32'h0000_FFFF);
        xfer("t4_rd_cmph", 1'b0, 1'b0, 16'h4004, 32'h0, 4'hF, 32'h0);
        xfer("t4_wr_cmph_b2", 1'b0, 1'b1, 16'h4004, 32'hAABB_CCDD, 4'b0100, 32'h0);
        xfer("t4_rd_cmph_b2", 1'b0, 1'b0, 16'h4004, 32'h0, 4'hF, 32'h00BB_0000);

        // Test 5: PRESCALE=4, write MTIME_L on a tick cycle
        @(negedge CLK);
        prev  = mtime4;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge CLK);
            if (mtime4 != prev) found = 1'b1;
        end
        check("t5_sync", {63'b0, found}, 64'd1);
        repeat (3) @(negedge CLK);
        xfer("t5_wr_mtl", 1'b1, 1'b1, 16'hBFF8, 32'h100, 4'hF, 32'h0);
        check("t5_no_inc", mtime4, 64'h100);
        repeat (3) @(negedge CLK);
        check("t5_hold", mtime4, 64'h100);
        @(negedge CLK);
        check("t5_next_inc", mtime4, 64'h101);

        // Test 6: reset during a pending request, then req held through the ack cycle
        @(negedge CLK);
        wen = 1'b1; addr = 16'h0000; wdata = 32'h1; byte_en = 4'hF; req1 = 1'b1;
        #2 nRST = 1'b0;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (ack1) acks++;
        end
        check("t6_no_ack", acks, 64'd0);
        check("t6_mtime_rst", mtime1, 64'd0);
        check("t6_sint_rst", {63'b0, si1}, 64'd0);
        check("t6_tint_rst", {63'b0, ti1}, 64'd0);
        req1 = 1'b0;
        nRST = 1'b1;
        @(negedge CLK);
        xfer("t6_rd_cmph", 1'b0, 1'b0, 16'h4004, 32'h0, 4'hF, 32'hFFFF_FFFF);
        xfer("t6_rd_cmpl", 1'b0, 1'b0, 16'h4000, 32'h0, 4'hF, 32'hFFFF_FFFF);
        xfer("t6_rd_msip", 1'b0, 1'b0, 16'h0000, 32'h0, 4'hF, 32'h0);
        @(negedge CLK);
        wen = 1'b0; addr = 16'h0000; req1 = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (ack1) acks++;
            if (i == 1) req1 = 1'b0;
        end
        check("t6_single_ack", acks, 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
